// File: rtl/not_gate_pkg.sv
// Shared constants, the occupancy-state type for the skid buffer, and the
// bitwise-invert helper used by both the combinational and streaming paths.
package not_gate_pkg;

   localparam int NOT_GATE_MAX_WIDTH = 64;

   // Occupancy of the 2-entry skid buffer: nothing, main only, main + skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_st_e;

   // Callers zero-extend narrower vectors into the full width and cast the result back.
   function automatic logic [NOT_GATE_MAX_WIDTH-1:0] inv_vec(
      input logic [NOT_GATE_MAX_WIDTH-1:0] v);
      return ~v;
   endfunction

endpackage

// File: rtl/not_gate_if.sv
// Valid/ready streaming bus for not_gate. out_parity exists only when
// NOT_GATE_PARITY_EN is defined.
interface not_gate_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef NOT_GATE_PARITY_EN
   logic             out_parity;
`endif

   // The not_gate block side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
`ifdef NOT_GATE_PARITY_EN
      , output out_parity
`endif
   );

   // The producer/consumer side.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
`ifdef NOT_GATE_PARITY_EN
      , input out_parity
`endif
   );
endinterface

// File: rtl/not_gate_skid.sv
// Generic DW-bit 2-entry valid/ready skid buffer. The main register drives
// the output; the skid register absorbs one beat while the output stalls.
// in_ready depends only on stored state and rst_n, never on out_ready.
module not_gate_skid
   import not_gate_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_in_data,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_out_data
);

   skid_st_e      r_state, w_state_nxt;
   logic [DW-1:0] r_m, r_s, w_m_nxt, w_s_nxt;
   logic          w_acc, w_dlv;

   assign o_in_ready  = rst_n & (r_state != ST_FULL);
   assign o_out_valid = (r_state != ST_EMPTY);
   assign o_out_data  = r_m;
   assign w_acc       = i_in_valid & o_in_ready;
   assign w_dlv       = o_out_valid & i_out_ready;

   // Next occupancy and entry contents from accept/deliver events.
   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_s_nxt     = r_s;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_m_nxt     = i_in_data;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_acc && w_dlv) begin
               w_m_nxt = i_in_data;
            end else if (w_acc) begin
               w_s_nxt     = i_in_data;
               w_state_nxt = ST_FULL;
            end else if (w_dlv) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a delivery can happen.
            if (w_dlv) begin
               w_m_nxt     = r_s;
               w_state_nxt = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // State and entry registers; reset discards any beats in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_m     <= '0;
         r_s     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_m     <= w_m_nxt;
         r_s     <= w_s_nxt;
      end
   end

endmodule

// File: rtl/not_gate.sv
// Parameterised bitwise inverter: combinational y = ~a plus a registered
// valid/ready streaming path that stores ~in_data in a 2-entry skid buffer.
// Optional macro NOT_GATE_PARITY_EN adds out_parity = ^out_data, carried as
// an extra payload bit through the skid buffer.
// TPD is a simulation delay hint only; the synthesizable model has no delay.
module not_gate
   import not_gate_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int TPD   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y,
   not_gate_if.slave        bus
);

   if (WIDTH < 1 || WIDTH > NOT_GATE_MAX_WIDTH) begin : g_bad_width
      $error("not_gate: WIDTH out of range 1..64");
   end
   if (TPD < 0) begin : g_bad_tpd
      $error("not_gate: TPD must be non-negative");
   end

`ifdef NOT_GATE_PARITY_EN
   localparam int PW = WIDTH + 1;
`else
   localparam int PW = WIDTH;
`endif

   logic [WIDTH-1:0] w_inv;
   logic [PW-1:0]    w_pay_in, w_pay_out;

   // Gate path: pure inverter, independent of clk/rst_n.
   assign y     = WIDTH'(inv_vec(NOT_GATE_MAX_WIDTH'(a)));

   // Inversion happens before capture so the buffer only ever holds ~in_data.
   assign w_inv = WIDTH'(inv_vec(NOT_GATE_MAX_WIDTH'(bus.in_data)));

`ifdef NOT_GATE_PARITY_EN
   assign w_pay_in       = {^w_inv, w_inv};
   assign bus.out_parity = w_pay_out[WIDTH];
`else
   assign w_pay_in       = w_inv;
`endif
   assign bus.out_data   = w_pay_out[WIDTH-1:0];

   not_gate_skid #(.DW(PW)) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (bus.in_valid),
      .o_in_ready  (bus.in_ready),
      .i_in_data   (w_pay_in),
      .o_out_valid (bus.out_valid),
      .i_out_ready (bus.out_ready),
      .o_out_data  (w_pay_out)
   );

endmodule

// File: tb/tb_not_gate.sv
// Directed bench for not_gate (WIDTH=8): gate path, reset, streaming,
// backpressure, mid-operation reset and, with NOT_GATE_PARITY_EN, parity.
module tb_not_gate;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, y;
   int         n_chk = 0;
   int         n_err = 0;

   not_gate_if #(.WIDTH(8)) bus ();

   not_gate #(.WIDTH(8), .TPD(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .y     (y),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      a             = 8'h00;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;

      // Gate path
      a = 8'h00; #1; chk("y_00", y, 8'hFF);
      a = 8'hA5; #1; chk("y_a5", y, 8'h5A);
      a = 8'h3C; #1; chk("y_3c", y, 8'hC3);
      a = 8'hFF; #1; chk("y_ff", y, 8'h00);

      // Reset held for 2 edges with a beat offered
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h12;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ovld", bus.out_valid, 1'b0);
         chk("rst_irdy", bus.in_ready, 1'b0);
`ifdef NOT_GATE_PARITY_EN
         chk("rst_par", bus.out_parity, 1'b0);
`endif
      end
      rst_n = 1'b1; #1;
      chk("rel_irdy", bus.in_ready, 1'b1);
      tick();
      chk("first_ovld", bus.out_valid, 1'b1);
      chk("first_data", bus.out_data, 8'hED);

      // Back-to-back streaming, out_ready high
      bus.in_data = 8'h01; tick();
      chk("s1_data", bus.out_data, 8'hFE); chk("s1_irdy", bus.in_ready, 1'b1);
      bus.in_data = 8'h02; tick();
      chk("s2_data", bus.out_data, 8'hFD); chk("s2_ovld", bus.out_valid, 1'b1);
      bus.in_data = 8'h03; tick();
      chk("s3_data", bus.out_data, 8'hFC); chk("s3_ovld", bus.out_valid, 1'b1);
      bus.in_valid = 1'b0; tick();
      chk("s_drain", bus.out_valid, 1'b0);

      // Backpressure fills both entries
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h10; tick();
      chk("bp1_data", bus.out_data, 8'hEF); chk("bp1_irdy", bus.in_ready, 1'b1);
      bus.in_data = 8'h20; tick();
      chk("bp2_irdy", bus.in_ready, 1'b0); chk("bp2_data", bus.out_data, 8'hEF);
      bus.in_data = 8'h99; tick();   // must be ignored: buffer full
      chk("bp3_data", bus.out_data, 8'hEF); chk("bp3_ovld", bus.out_valid, 1'b1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1; tick();
      chk("bp4_data", bus.out_data, 8'hDF); chk("bp4_irdy", bus.in_ready, 1'b1);
      tick();
      chk("bp5_ovld", bus.out_valid, 1'b0);

      // Mid-operation reset with both entries full
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hAA; tick();
      bus.in_data   = 8'h55; tick();
      chk("mr_full", bus.in_ready, 1'b0);
      bus.in_valid = 1'b0;
      rst_n = 1'b0; tick();
      chk("mr_ovld", bus.out_valid, 1'b0);
      chk("mr_data", bus.out_data, 8'h00);
      rst_n = 1'b1; #1;
      chk("mr_irdy", bus.in_ready, 1'b1);
      tick();
      chk("mr_empty", bus.out_valid, 1'b0);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h0F; tick();
      chk("mr_beat_v", bus.out_valid, 1'b1); chk("mr_beat_d", bus.out_data, 8'hF0);
      bus.in_valid = 1'b0; tick();
      chk("mr_only", bus.out_valid, 1'b0);

`ifdef NOT_GATE_PARITY_EN
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h07; tick();
      chk("p1_data", bus.out_data, 8'hF8); chk("p1_par", bus.out_parity, 1'b1);
      bus.out_ready = 1'b1;
      bus.in_data   = 8'h03; tick();
      chk("p2_data", bus.out_data, 8'hFC); chk("p2_par", bus.out_parity, 1'b0);
      bus.in_valid = 1'b0; tick();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/not_gate.md
Name: not_gate

Overview:
- Parameterised bitwise inverter: the team's gate-level NOT primitive, extended with a registered, flow-controlled streaming path.
- Combinational path: y = ~a, for gate-level netlists such as the FSM next-state logic.
- Streaming path: inverts each accepted beat and returns it through a valid/ready handshake with 1-cycle latency and full throughput.

Parameters:
- WIDTH, 1, bit width of a/y and of in_data/out_data (legal range 1..64).
- TPD, 0, simulation-only propagation delay (time units) on the combinational output y; ignored by synthesis.

Ports:
- clk  input  1  rising-edge clock for the streaming path.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  combinational gate input.
- y  output  WIDTH  combinational gate output, y = ~a after TPD.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  inverted payload, out_data = ~in_data of the accepted beat.

Behaviour:
- Combinational path:
  - y = ~a, bit-for-bit, independent of clk and rst_n.
  - For WIDTH=1, y is a plain inverter.
  - X/Z on a bit of a propagates as X on that bit of y.
- Streaming path structure:
  - 2-entry skid buffer: main register M drives out_data/out_valid; skid register S holds one overflow beat.
  - Inversion happens on capture: M/S always store ~in_data.
  - in_ready = rst_n & ~S_valid (registered, no combinational path from out_ready).
- Handshake:
  - Accept when in_valid & in_ready.
  - Deliver when out_valid & out_ready.
  - in_data is sampled only on accept.
  - Per clock edge with rst_n=1:
    - Accept, M empty or M delivered this cycle, S empty: M <= ~in_data.
    - Accept while M holds an undelivered beat: S <= ~in_data, S_valid <= 1.
    - M delivered and S_valid=1: M <= S, S_valid <= 0. in_ready is 0 that cycle, so no simultaneous accept.
    - M delivered, no accept, S empty: out_valid <= 0.
- Latency and throughput:
  - Accept-to-out_valid latency: exactly 1 cycle.
  - Sustained 1 beat/cycle with out_ready held high.
  - Beats are never dropped, duplicated or reordered.
- out_data/out_valid stability: while out_valid=1 and out_ready=0, both hold stable until delivery.
- Reset (rst_n=0 sampled at a rising edge):
  - M and S are invalidated; out_valid=0, in_ready=0; stored data cleared to 0.
  - Beats in flight when reset is applied mid-operation are discarded.
  - First accept is possible on the first edge after rst_n returns high.
- Boundary conditions:
  - Both entries full: in_ready=0; in_valid is ignored.
  - in_valid and out_ready both high with only M full: deliver M and load M with the new beat in the same edge; S stays empty.

Optional Feature:
- Macro: NOT_GATE_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = even parity (XOR reduction) of out_data.
  - Registered alongside M/S and valid exactly when out_valid=1.
  - 0 after reset.
- Undefined: port absent, no parity logic; all other behaviour identical.

Decomposition:
- Shared package not_gate_pkg:
  - constant NOT_GATE_MAX_WIDTH = 64;
  - function inv_vec (bitwise invert, used by both paths).
- One sub-module: not_gate_skid, a generic WIDTH-bit 2-entry valid/ready skid buffer with clk/rst_n.
  - not_gate instantiates it with ~in_data as its input payload.
  - The combinational y path stays at top level.

Test Plan:
- Combinational, WIDTH=8, TPD=0: a=8'h00 -> y=8'hFF; a=8'hA5 -> y=8'h5A; a=8'h3C -> y=8'hC3.
- Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=8'h12 -> out_valid=0, in_ready=0 throughout.
  - After release, first accepted beat 8'h12 appears as out_data=8'hED one cycle later.
- Streaming with out_ready=1: send 8'h01, 8'h02, 8'h03 back-to-back -> out_data 8'hFE, 8'hFD, 8'hFC on consecutive cycles, each 1 cycle after accept.
- Backpressure: out_ready=0, send 8'h10 then 8'h20 -> in_ready drops after the second accept.
  - out_data holds 8'hEF stably.
  - Raising out_ready delivers 8'hEF then 8'hDF, and in_ready returns to 1.
- Mid-operation reset: both entries full (8'hAA, 8'h55 sent), assert rst_n=0 for one edge -> out_valid=0, buffer empty.
  - The next beat 8'h0F yields 8'hF0 only.
- NOT_GATE_PARITY_EN defined: in_data=8'h07 -> out_data=8'hF8, out_parity=1.
  - in_data=8'h03 -> out_data=8'hFC, out_parity=0.
